// File: rtl/nrd_rem_correct.sv
// Remainder-correction and result stage behind the 16-bit non-restoring array divider.
// Two-entry valid/ready pipeline: S1 holds the raw result, S2 holds the corrected result.
module nrd_rem_correct (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] quo_in,
    input  logic [15:0] rem_in,
    input  logic [15:0] dividend_in,
    input  logic [15:0] divisor_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quo_out,
    output logic [15:0] rem_out,
    output logic        dz,
    output logic        ovf,
    output logic [15:0] corr_cnt
);

    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_quo_q, s1_quo_d;
    logic [15:0] s1_rem_q, s1_rem_d;
    logic [15:0] s1_dvd_q, s1_dvd_d;
    logic [15:0] s1_dvs_q, s1_dvs_d;

    logic        out_valid_q, out_valid_d;
    logic [15:0] quo_out_q, quo_out_d;
    logic [15:0] rem_out_q, rem_out_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [15:0] corr_cnt_q, corr_cnt_d;

    logic        s2_free;
    logic        s1_adv;
    logic        in_xfer;

    logic [15:0] add_sum;
    logic [15:0] add_carry;

    logic [15:0] res_quo;
    logic [15:0] res_rem;
    logic        res_dz;
    logic        res_ovf;
    logic        res_corr;

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_xfer  = in_valid && in_ready;

    // Ripple-carry add-back; the carry out of bit 15 is intentionally never formed.
    always_comb begin
        add_carry = '0;
        for (int i = 0; i < 15; i++) begin
            add_carry[i+1] = (s1_rem_q[i] & s1_dvs_q[i]) |
                             (add_carry[i] & (s1_rem_q[i] ^ s1_dvs_q[i]));
        end
        add_sum = s1_rem_q ^ s1_dvs_q ^ add_carry;
    end

    always_comb begin
        res_quo  = s1_quo_q;
        res_rem  = s1_rem_q;
        res_dz   = 1'b0;
        res_ovf  = 1'b0;
        res_corr = 1'b0;
        if (s1_dvs_q == 16'h0000) begin
            res_quo = 16'hFFFF;
            res_rem = s1_dvd_q;
            res_dz  = 1'b1;
        end else if (s1_dvs_q[15]) begin
            res_quo = 16'h0000;
            res_rem = s1_dvd_q;
            res_ovf = 1'b1;
        end else if (s1_rem_q[15]) begin
            res_rem  = add_sum;
            res_corr = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_quo_d   = s1_quo_q;
        s1_rem_d   = s1_rem_q;
        s1_dvd_d   = s1_dvd_q;
        s1_dvs_d   = s1_dvs_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_quo_d   = quo_in;
            s1_rem_d   = rem_in;
            s1_dvd_d   = dividend_in;
            s1_dvs_d   = divisor_in;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        quo_out_d   = quo_out_q;
        rem_out_d   = rem_out_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        corr_cnt_d  = corr_cnt_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
            quo_out_d   = res_quo;
            rem_out_d   = res_rem;
            dz_d        = res_dz;
            ovf_d       = res_ovf;
            if (res_corr && (corr_cnt_q != 16'hFFFF)) begin
                corr_cnt_d = corr_cnt_q + 16'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_quo_q    <= '0;
            s1_rem_q    <= '0;
            s1_dvd_q    <= '0;
            s1_dvs_q    <= '0;
            out_valid_q <= 1'b0;
            quo_out_q   <= '0;
            rem_out_q   <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            corr_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_quo_q    <= s1_quo_d;
            s1_rem_q    <= s1_rem_d;
            s1_dvd_q    <= s1_dvd_d;
            s1_dvs_q    <= s1_dvs_d;
            out_valid_q <= out_valid_d;
            quo_out_q   <= quo_out_d;
            rem_out_q   <= rem_out_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            corr_cnt_q  <= corr_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign quo_out   = quo_out_q;
    assign rem_out   = rem_out_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;
    assign corr_cnt  = corr_cnt_q;

endmodule

// File: tb/tb_nrd_rem_correct.sv
// Directed and random-stream checks of nrd_rem_correct.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nrd_rem_correct;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] quo_in;
    logic [15:0] rem_in;
    logic [15:0] dividend_in;
    logic [15:0] divisor_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quo_out;
    logic [15:0] rem_out;
    logic        dz;
    logic        ovf;
    logic [15:0] corr_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_corr = 16'd0;

    nrd_rem_correct dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .quo_in     (quo_in),
        .rem_in     (rem_in),
        .dividend_in(dividend_in),
        .divisor_in (divisor_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quo_out    (quo_out),
        .rem_out    (rem_out),
        .dz         (dz),
        .ovf        (ovf),
        .corr_cnt   (corr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] q, input logic [15:0] r,
                         input logic [15:0] a, input logic [15:0] d);
        in_valid    = 1'b1;
        quo_in      = q;
        rem_in      = r;
        dividend_in = a;
        divisor_in  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++;
        if ({out_valid, quo_out, rem_out, dz, ovf} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b q=%h r=%h dz=%b ovf=%b want all zero",
                     out_valid, quo_out, rem_out, dz, ovf);
        end
        total++;
        if (corr_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_corr_cnt: got %h want 0000", corr_cnt);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_plain();
        out_ready = 1'b1;
        drive(16'd2, 16'd24, 16'd90, 16'd33);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL plain_in_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL plain_early_valid: got %b want 0 one edge after accept", out_valid);
        end
        step();
        total++;
        if ({out_valid, quo_out, rem_out, dz, ovf, corr_cnt} !==
            {1'b1, 16'd2, 16'd24, 1'b0, 1'b0, exp_corr}) begin
            bad++;
            $display("FAIL plain_result: got v=%b q=%h r=%h dz=%b ovf=%b cnt=%h want 1/0002/0018/0/0/%h",
                     out_valid, quo_out, rem_out, dz, ovf, corr_cnt, exp_corr);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL plain_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_addback();
        out_ready = 1'b1;
        drive(16'd3, 16'hFED5, 16'd901, 16'd300);
        step();
        in_valid = 1'b0;
        step();
        exp_corr = exp_corr + 16'd1;
        total++;
        if ({out_valid, quo_out, rem_out, dz, ovf, corr_cnt} !==
            {1'b1, 16'd3, 16'd1, 1'b0, 1'b0, exp_corr}) begin
            bad++;
            $display("FAIL addback: got v=%b q=%h r=%h dz=%b ovf=%b cnt=%h want 1/0003/0001/0/0/%h",
                     out_valid, quo_out, rem_out, dz, ovf, corr_cnt, exp_corr);
        end
        step();
    endtask

    task automatic test_dz_ovf();
        out_ready = 1'b1;
        drive(16'h1234, 16'h8000, 16'd901, 16'd0);
        step();
        drive(16'h5678, 16'hFFFF, 16'd5, 16'h8001);
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, quo_out, rem_out, dz, ovf} !== {1'b1, 16'hFFFF, 16'd901, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL div_zero: got v=%b q=%h r=%h dz=%b ovf=%b want 1/ffff/0385/1/0",
                     out_valid, quo_out, rem_out, dz, ovf);
        end
        step();
        total++;
        if ({out_valid, quo_out, rem_out, dz, ovf} !== {1'b1, 16'h0000, 16'd5, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL out_of_range: got v=%b q=%h r=%h dz=%b ovf=%b want 1/0000/0005/0/1",
                     out_valid, quo_out, rem_out, dz, ovf);
        end
        total++;
        if (corr_cnt !== exp_corr) begin
            bad++;
            $display("FAIL dz_ovf_corr_cnt: got %h want %h", corr_cnt, exp_corr);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(16'd10, 16'd1, 16'd51, 16'd5);
        step();
        drive(16'd7, 16'hFFFE, 16'd30, 16'd4);
        step();
        drive(16'd1, 16'd0, 16'd9, 16'd9);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
        end
        total++;
        if ({out_valid, quo_out, rem_out, dz, ovf} !== {1'b1, 16'd10, 16'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL bp_first: got v=%b q=%h r=%h want 1/000a/0001", out_valid, quo_out, rem_out);
        end
        step();
        total++;
        if ({out_valid, quo_out, rem_out, dz, ovf, in_ready} !==
            {1'b1, 16'd10, 16'd1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL bp_hold: got v=%b q=%h r=%h rdy=%b want 1/000a/0001/0",
                     out_valid, quo_out, rem_out, in_ready);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_in_ready_comb: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, quo_out, rem_out} !== {1'b1, 16'd7, 16'd2}) begin
            bad++;
            $display("FAIL bp_second: got v=%b q=%h r=%h want 1/0007/0002", out_valid, quo_out, rem_out);
        end
        step();
        exp_corr = exp_corr + 16'd1;
        total++;
        if ({out_valid, quo_out, rem_out, corr_cnt} !== {1'b1, 16'd1, 16'd0, exp_corr}) begin
            bad++;
            $display("FAIL bp_third: got v=%b q=%h r=%h cnt=%h want 1/0001/0000/%h",
                     out_valid, quo_out, rem_out, corr_cnt, exp_corr);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [33:0] model_q[$];
        logic [33:0] want;
        logic [15:0] a, d, q, r;
        logic        neg;
        int sent = 0;
        int got  = 0;
        int negs = 0;
        int cyc  = 0;
        a = '0; d = 16'd1; q = '0; r = '0; neg = 1'b0;
        while ((sent < 100 || model_q.size() != 0) && cyc < 3000) begin
            if (sent < 100 && $urandom_range(0, 1) == 1) begin
                d   = 16'($urandom_range(1, 16'h7FFF));
                a   = 16'($urandom_range(0, 16'hFFFF));
                q   = a / d;
                r   = a % d;
                neg = 1'($urandom_range(0, 1));
                drive(q, neg ? (r - d) : r, a, d);
            end else begin
                in_valid = 1'b0;
                divisor_in = 16'($urandom_range(0, 16'hFFFF));
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (model_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra: got q=%h r=%h with no result pending", quo_out, rem_out);
                end else begin
                    want = model_q.pop_front();
                    if ({quo_out, rem_out, dz, ovf} !== want) begin
                        bad++;
                        $display("FAIL stream_item%0d: got q=%h r=%h dz=%b ovf=%b want q=%h r=%h dz=0 ovf=0",
                                 got, quo_out, rem_out, dz, ovf, want[33:18], want[17:2]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                model_q.push_back({q, r, 2'b00});
                sent++;
                if (neg) negs++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (cyc >= 3000 || got != 100) begin
            bad++;
            $display("FAIL stream_count: got %0d results in %0d cycles want 100", got, cyc);
        end
        exp_corr = exp_corr + 16'(negs);
        total++;
        if (corr_cnt !== exp_corr) begin
            bad++;
            $display("FAIL stream_corr_cnt: got %h want %h", corr_cnt, exp_corr);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(16'd9, 16'hFFF0, 16'd77, 16'd20);
        step();
        drive(16'd8, 16'hFFF1, 16'd66, 16'd20);
        step();
        drive(16'd5, 16'd5, 16'd55, 16'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_corr = 16'd0;
        total++;
        if ({out_valid, corr_cnt, in_ready} !== {1'b0, 16'd0, 1'b1}) begin
            bad++;
            $display("FAIL rst_mid: got v=%b cnt=%h rdy=%b want 0/0000/1", out_valid, corr_cnt, in_ready);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_stale: got out_valid=%b want 0", out_valid);
        end
        drive(16'd4, 16'd3, 16'd23, 16'd5);
        step();
        in_valid = 1'b0;
        step();
        total++;
        if ({out_valid, quo_out, rem_out, corr_cnt} !== {1'b1, 16'd4, 16'd3, 16'd0}) begin
            bad++;
            $display("FAIL rst_mid_first: got v=%b q=%h r=%h cnt=%h want 1/0004/0003/0000",
                     out_valid, quo_out, rem_out, corr_cnt);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_dup: got out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        quo_in      = '0;
        rem_in      = '0;
        dividend_in = '0;
        divisor_in  = '0;
        @(negedge clk);
        test_reset();
        test_plain();
        test_addback();
        test_dz_ovf();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nrd_rem_correct.md
# nrd_rem_correct

Registered remainder-correction and result stage placed directly downstream of the 16-bit combinational non-restoring array divider. It accepts the raw quotient and raw remainder, adds the divisor back when the raw remainder is negative, and traps divide-by-zero and out-of-range divisors. It presents the final quotient and remainder through a 2-stage valid/ready pipeline with full backpressure.

## Interface
- No parameters; datapath width fixed at 16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream presents a divider result.
- in_ready  out  1  stage can accept this cycle.
- quo_in  in  16  raw quotient bits from the divider array.
- rem_in  in  16  raw remainder from the array, two's complement; bit 15 is the sign.
- dividend_in  in  16  original dividend, carried alongside for the divide-by-zero result.
- divisor_in  in  16  original divisor.
- out_valid  out  1  final result available.
- out_ready  in  1  downstream accepts this cycle.
- quo_out  out  16  final quotient.
- rem_out  out  16  final non-negative remainder.
- dz  out  1  divide-by-zero flag for the current result.
- ovf  out  1  divisor out of range (divisor_in[15]=1) for the current result.
- corr_cnt  out  16  saturating count of results where the add-back was applied.

## Operation
- Stage S1 is the input register. It captures quo_in, rem_in, dividend_in and divisor_in on an input transfer (in_valid && in_ready).
- Stage S2 is the output register. It captures the corrected result computed from S1 when S1 advances.
- Correction rules, in priority order:
  - Divide-by-zero: if divisor==0, quo_out=16'hFFFF, rem_out=dividend, dz=1, ovf=0, no add-back.
  - Out-of-range divisor: else if divisor[15]=1, quo_out=16'h0000, rem_out=dividend, ovf=1, dz=0.
  - Negative remainder: else if rem[15]=1, rem_out=(rem+divisor) mod 2^16 and quo_out=quo.
  - Otherwise: rem_out=rem and quo_out=quo.
- The add-back uses a 16-bit ripple-carry adder. Its carry-out is discarded.
- corr_cnt increments by 1 when a result with an applied add-back is written into S2. It saturates at 16'hFFFF and is cleared only by rst.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - S1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free.
- A simultaneous input transfer and S1 advance in the same cycle is legal: S1 reloads and S2 loads the old S1 content.
- While out_valid && !out_ready, quo_out, rem_out, dz and ovf hold stable.
- Results leave in strict arrival order. The stage never drops or duplicates a result.
- Input fields are ignored when in_valid=0.

## Timing
- Latency: an input accepted at edge N gives out_valid=1 after edge N+1, provided S2 is free.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Capacity is 2 results (S1 + S2). in_ready falls combinationally when both stages are full and out_ready=0.
- in_ready has a combinational path from out_ready only. There is no path from in_valid to in_ready.
- Reset values, taking effect at the first edge with rst=1:
  - s1_valid=0, out_valid=0.
  - quo_out=0, rem_out=0, dz=0, ovf=0, corr_cnt=0.
  - in_ready=1 during and after reset.
- Reset mid-operation: every in-flight result is discarded at that edge and none appear after reset. An input presented during the reset cycle is not accepted.

## Test plan
- Plain result: quo_in=2, rem_in=24, dividend=90, divisor=33, out_ready=1. Required: quo_out=2, rem_out=24, dz=0, ovf=0, corr_cnt=0, with out_valid exactly 2 edges after acceptance.
- Add-back: quo_in=3, rem_in=16'hFED5 (-299), divisor=300, dividend=901. Required: quo_out=3, rem_out=1, corr_cnt=1.
- Divide-by-zero then out-of-range: (dividend=901, divisor=0), then (dividend=5, divisor=16'h8001). Required: first FFFF/901/dz=1; next 0000/5/ovf=1; corr_cnt unchanged.
- Backpressure: push 3 back-to-back results with out_ready=0. Required: in_ready=0 once 2 results are held; outputs stable. Then set out_ready=1 for 3 cycles. Required: all 3 results emerge in order, with no gap after the first.
- Streaming: 100 random legal results, with in_valid and out_ready each randomly 1 at 50%. Required: output matches the reference model in order; corr_cnt equals the number of negative remainders.
- Reset mid-operation: assert rst with both stages full. Required: out_valid=0 and corr_cnt=0 on the next cycle, and the first post-reset input is the first output.
